// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_D  = 2'd1,
        BUSY_I  = 2'd2,
        DRAIN_I = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Round-robin pick: a lone requester wins, a conflict goes to whoever
    // was not granted last.
    function automatic owner_t arb_pick(input logic dm, input logic fi, input owner_t last);
        if (dm && fi) begin
            return (last == OWN_DM) ? OWN_IF : OWN_DM;
        end else if (dm) begin
            return OWN_DM;
        end else begin
            return OWN_IF;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Wait-cycle counter for one memory transaction; flags the terminal wait cycle.
module wait_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    // o_tc marks the cycle that would be the TIMEOUT-th wait without mem_ready.
    localparam logic [7:0] TC_VALUE = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    // Clear on every new grant, count each cycle spent waiting on memory.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-outstanding unified memory port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    arb_state_t  r_state;
    owner_t      r_last_grant;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    arb_state_t  w_next;
    owner_t      w_owner;
    owner_t      w_arb_last;
    owner_t      w_pick;
    logic        w_busy;
    logic        w_in_busy;
    logic        w_grant;
    logic        w_tc;
    logic        w_count_en;
    logic        w_abort;
    logic        w_finish;

    assign w_busy     = (r_state != IDLE);
    assign w_in_busy  = (r_state == BUSY_D) || (r_state == BUSY_I);
    assign w_owner    = (r_state == BUSY_D) ? OWN_DM : OWN_IF;
    assign w_count_en = w_busy && !mem_ready;
    assign w_abort    = w_busy && !mem_ready && w_tc;
    // Transaction ends this cycle, by completion or by timeout.
    assign w_finish   = mem_ready || w_tc;

    // On completion the owner becomes last_grant in the same cycle, so the
    // back-to-back pick uses it directly to hand over without an IDLE bubble.
    assign w_arb_last = (r_state == IDLE) ? r_last_grant : w_owner;
    assign w_pick     = arb_pick(dm_req, if_req, w_arb_last);

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .i_clear(w_grant),
        .i_en   (w_count_en),
        .o_tc   (w_tc)
    );

    // Next-state and grant decision.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (dm_req || if_req) begin
                    w_grant = 1'b1;
                end
            end
            BUSY_D, BUSY_I: begin
                if (mem_ready) begin
                    if (dm_req || if_req) begin
                        w_grant = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end else if (w_tc) begin
                    w_next = IDLE;
                end else if ((r_state == BUSY_I) && if_flush) begin
                    w_next = DRAIN_I;
                end
            end
            DRAIN_I: begin
                if (w_finish) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_grant) begin
            w_next = (w_pick == OWN_DM) ? BUSY_D : BUSY_I;
        end
    end

    // State, round-robin history and latched transaction fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= OWN_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
        end else begin
            r_state <= w_next;
            if (w_in_busy && mem_ready) begin
                r_last_grant <= w_owner;
            end
            if (w_grant) begin
                if (w_pick == OWN_DM) begin
                    r_we    <= dm_we;
                    r_addr  <= dm_addr;
                    r_wdata <= dm_wdata;
                    r_be    <= dm_be;
                end else begin
                    r_we    <= 1'b0;
                    r_addr  <= if_addr;
                    r_wdata <= '0;
                    r_be    <= '1;
                end
            end
        end
    end

    assign mem_req   = w_busy && !reset;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

    // A flush coinciding with completion retires the fetch silently.
    assign if_ack   = (r_state == BUSY_I) && w_finish && !if_flush && !reset;
    assign dm_ack   = (r_state == BUSY_D) && w_finish && !reset;
    assign if_rdata = (if_ack && mem_ready) ? mem_rdata : '0;
    assign dm_rdata = (dm_ack && mem_ready) ? mem_rdata : '0;
    assign bus_err  = w_abort && !reset;

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural memory of programmable latency.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_if, stall_mem, bus_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_if[$];
    logic [31:0] q_dm[$];

    int          mem_lat = 0;
    int          mem_wc  = 0;
    logic [31:0] txn_addr = '0;
    logic [31:0] st_addr  = '0;
    logic [31:0] st_data  = '0;
    logic [3:0]  st_be    = '0;

    mem_arbiter #(.TIMEOUT(4)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_be    (dm_be),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: answers after mem_lat wait cycles, logs stores, checks address hold.
    always @(posedge clk) begin
        #2;
        if (mem_req) begin
            if (mem_wc == 0) txn_addr = mem_addr;
            else check("mem_addr_hold", mem_addr, txn_addr);
            if (mem_wc == mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_we ? 32'h0 : mem_fn(mem_addr);
                if (mem_we) begin
                    st_addr = mem_addr;
                    st_data = mem_wdata;
                    st_be   = mem_be;
                end
                mem_wc = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = '0;
                mem_wc++;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = '0;
            mem_wc    = 0;
        end
    end

    logic [31:0] e_if, e_dm;

    // Scoreboard: every ack pops the oldest expectation for its port.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_ack) begin
                if (q_if.size() == 0) check("if_ack_unexpected", {31'b0, if_ack}, 32'h0);
                else begin
                    e_if = q_if.pop_front();
                    check("if_rdata", if_rdata, e_if);
                end
            end else begin
                check("if_rdata_zero", if_rdata, 32'h0);
            end
            if (dm_ack) begin
                if (q_dm.size() == 0) check("dm_ack_unexpected", {31'b0, dm_ack}, 32'h0);
                else begin
                    e_dm = q_dm.pop_front();
                    check("dm_rdata", dm_rdata, e_dm);
                end
            end else begin
                check("dm_rdata_zero", dm_rdata, 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_if(output int cyc);
        bit got;
        got = 0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (if_ack) begin
                got = 1;
                if_req = 1'b0;
            end
        end
        check("if_ack_wait", {31'b0, got}, 32'h1);
    endtask

    task automatic wait_dm(output int cyc);
        bit got;
        got = 0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (dm_ack) begin
                got = 1;
                dm_req = 1'b0;
                dm_we  = 1'b0;
            end
        end
        check("dm_ack_wait", {31'b0, got}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        int budget;
        int seq[6];

        reset = 1'b1;
        if_req = 0; if_addr = '0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_ready = 0; mem_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_if_ack", {31'b0, if_ack}, 32'h0);
        check("rst_dm_ack", {31'b0, dm_ack}, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle_mem_req", {31'b0, mem_req}, 32'h0);
        check("idle_stall_if", {31'b0, stall_if}, 32'h0);

        // Lone fetch, memory answers two cycles after mem_req.
        step();
        mem_lat = 2; if_addr = 32'h0000_0040; if_req = 1;
        q_if.push_back(32'h0050_0093);
        @(negedge clk);
        check("f_stall_if", {31'b0, stall_if}, 32'h1);
        check("f_mem_req_n", {31'b0, mem_req}, 32'h0);
        wait_if(cyc);
        check("f_latency", cyc, 32'd3);
        @(negedge clk);
        check("f_post_stall_if", {31'b0, stall_if}, 32'h0);
        check("f_post_if_ack", {31'b0, if_ack}, 32'h0);
        check("f_post_mem_req", {31'b0, mem_req}, 32'h0);

        // Simultaneous store and fetch after reset: data first, no bubble.
        do_reset();
        step();
        mem_lat = 1;
        if_addr = 32'h0000_0100; if_req = 1;
        dm_addr = 32'h0000_1000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF; dm_we = 1; dm_req = 1;
        q_dm.push_back(32'h0);
        q_if.push_back(mem_fn(32'h0000_0100));
        @(negedge clk);
        check("c_mem_req_n", {31'b0, mem_req}, 32'h0);
        wait_dm(cyc);
        check("c_dm_latency", cyc, 32'd2);
        check("c_if_ack_n", {31'b0, if_ack}, 32'h0);
        check("c_st_addr", st_addr, 32'h0000_1000);
        check("c_st_data", st_data, 32'hDEAD_BEEF);
        check("c_st_be", {28'b0, st_be}, 32'hF);
        @(negedge clk);
        check("c_no_bubble", {31'b0, mem_req}, 32'h1);
        check("c_if_addr", mem_addr, 32'h0000_0100);
        check("c_if_we", {31'b0, mem_we}, 32'h0);
        wait_if(cyc);
        check("c_if_latency", cyc, 32'd1);
        @(negedge clk);
        check("c_end_mem_req", {31'b0, mem_req}, 32'h0);

        // Both held continuously: grants alternate starting with data.
        do_reset();
        step();
        mem_lat = 0;
        if_addr = 32'h0000_0200; if_req = 1;
        dm_addr = 32'h0000_2000; dm_we = 0; dm_req = 1;
        for (int i = 0; i < 3; i++) begin
            q_dm.push_back(mem_fn(32'h0000_2000));
            q_if.push_back(mem_fn(32'h0000_0200));
        end
        for (int i = 0; i < 6; i++) seq[i] = -1;
        n = 0;
        budget = 0;
        while (n < 6 && budget < 40) begin
            @(negedge clk);
            budget++;
            if (dm_ack) begin
                seq[n] = 1; n++;
            end else if (if_ack) begin
                seq[n] = 0; n++;
            end
            if (n == 6) begin
                if_req = 0;
                dm_req = 0;
            end
        end
        check("alt_count", n, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("alt_grant%0d", i), seq[i], (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("alt_end_mem_req", {31'b0, mem_req}, 32'h0);

        // Flush mid-fetch: drain without ack, address held.
        step();
        mem_lat = 3; if_addr = 32'h0000_0300; if_req = 1;
        @(negedge clk);
        step();
        if_flush = 1; if_req = 0;
        @(negedge clk);
        check("fl_if_ack", {31'b0, if_ack}, 32'h0);
        check("fl_mem_req", {31'b0, mem_req}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            if_flush = 0;
            @(negedge clk);
            check($sformatf("fl_drain_req%0d", k), {31'b0, mem_req}, 32'h1);
            check($sformatf("fl_drain_addr%0d", k), mem_addr, 32'h0000_0300);
            check($sformatf("fl_drain_ack%0d", k), {31'b0, if_ack}, 32'h0);
            check($sformatf("fl_drain_err%0d", k), {31'b0, bus_err}, 32'h0);
        end
        step();
        @(negedge clk);
        check("fl_idle_mem_req", {31'b0, mem_req}, 32'h0);

        // Flush coinciding with mem_ready: fetch retired, ack suppressed.
        step();
        mem_lat = 0; if_addr = 32'h0000_0340; if_req = 1;
        @(negedge clk);
        step();
        if_flush = 1; if_req = 0;
        @(negedge clk);
        check("flr_if_ack", {31'b0, if_ack}, 32'h0);
        check("flr_mem_req", {31'b0, mem_req}, 32'h1);
        step();
        if_flush = 0;
        @(negedge clk);
        check("flr_idle_mem_req", {31'b0, mem_req}, 32'h0);

        // Load never answered: abort on 4th wait cycle; flush has no effect here.
        step();
        mem_lat = 255; dm_addr = 32'h0000_3000; dm_we = 0; dm_req = 1; if_flush = 1;
        q_dm.push_back(32'h0);
        @(negedge clk);
        check("to_bus_err_n", {31'b0, bus_err}, 32'h0);
        wait_dm(cyc);
        check("to_latency", cyc, 32'd4);
        check("to_bus_err", {31'b0, bus_err}, 32'h1);
        @(negedge clk);
        check("to_mem_req", {31'b0, mem_req}, 32'h0);
        check("to_bus_err_end", {31'b0, bus_err}, 32'h0);
        step();
        if_flush = 0;

        // Reset during a data transaction: abandoned, then data wins next conflict.
        mem_lat = 255; dm_addr = 32'h0000_4000; dm_wdata = 32'h1234_5678; dm_be = 4'h3;
        dm_we = 1; dm_req = 1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("rm_pre_mem_req", {31'b0, mem_req}, 32'h1);
        step();
        reset = 1; dm_req = 0; dm_we = 0;
        @(negedge clk);
        check("rm_in_mem_req", {31'b0, mem_req}, 32'h0);
        check("rm_in_dm_ack", {31'b0, dm_ack}, 32'h0);
        check("rm_in_bus_err", {31'b0, bus_err}, 32'h0);
        step();
        reset = 0;
        @(negedge clk);
        check("rm_post_mem_req", {31'b0, mem_req}, 32'h0);
        check("rm_post_dm_ack", {31'b0, dm_ack}, 32'h0);
        step();
        mem_lat = 0;
        if_addr = 32'h0000_0500; if_req = 1;
        dm_addr = 32'h0000_5000; dm_we = 0; dm_req = 1;
        q_dm.push_back(mem_fn(32'h0000_5000));
        q_if.push_back(mem_fn(32'h0000_0500));
        @(negedge clk);
        @(negedge clk);
        check("rm_dm_first", {31'b0, dm_ack}, 32'h1);
        check("rm_if_wait", {31'b0, if_ack}, 32'h0);
        dm_req = 0;
        @(negedge clk);
        check("rm_if_second", {31'b0, if_ack}, 32'h1);
        if_req = 0;
        @(negedge clk);
        check("rm_end_mem_req", {31'b0, mem_req}, 32'h0);

        check("q_if_left", q_if.size(), 32'd0);
        check("q_dm_left", q_dm.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
